// File: rtl/fifo_read_packer_if.sv
// Signal bundle between the packer, the FIFO read port it drains and the
// downstream word consumer.
interface fifo_read_packer_if;
  // FIFO side: a byte leaves the FIFO at the clock edge where rinc=1.
  // rdata is only meaningful while rempty=0.
  // Word side: strict valid/ready. Once m_valid rises, m_data and m_keep
  // stay frozen until the edge where m_valid && m_ready. m_valid never
  // depends on m_ready combinationally.
  logic        rempty;
  logic [7:0]  rdata;
  logic        rinc;
  logic        flush;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [3:0]  m_keep;

  modport master (
    input  rempty,
    input  rdata,
    input  flush,
    input  m_ready,
    output rinc,
    output m_valid,
    output m_data,
    output m_keep
  );

  modport slave (
    output rempty,
    output rdata,
    output flush,
    output m_ready,
    input  rinc,
    input  m_valid,
    input  m_data,
    input  m_keep
  );
endinterface

// File: rtl/fifo_read_packer.sv
// Drains bytes from a FIFO read port and packs them little-endian into 32-bit
// words. A partial word is emitted on flush or after TIMEOUT idle cycles.
module fifo_read_packer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                  rclk,
  input  logic                  rrst,
  fifo_read_packer_if.master    bus,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_FULL  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [7:0]  idle_q, idle_d;
  logic        fp_q, fp_d;
  logic        m_valid_q, m_valid_d;
  logic [31:0] m_data_q, m_data_d;
  logic [3:0]  m_keep_q, m_keep_d;

  logic        slot_free;
  logic        xfer;
  logic        pop;
  logic        timeout_hit;
  logic        flush_req;

  always_comb begin
    slot_free   = !m_valid_q || bus.m_ready;
    xfer        = slot_free && (state_q == ST_FULL || state_q == ST_FLUSH);
    pop         = !rrst && !bus.rempty && !fp_q && (cnt_q < 3'd4 || xfer);
    timeout_hit = (state_q == ST_FILL) && bus.rempty && (idle_q == IDLE_LAST);
    // A flush that arrives while one is already pending is dropped.
    flush_req   = (bus.flush && !fp_q) || timeout_hit;
  end

  // Accumulator: a word leaving on xfer frees lane 0 for a same-cycle pop.
  always_comb begin
    acc_d = xfer ? 32'h0 : acc_q;
    cnt_d = xfer ? 3'd0 : cnt_q;
    if (pop) begin
      acc_d[{cnt_d[1:0], 3'b000} +: 8] = bus.rdata;
      cnt_d = cnt_d + 3'd1;
    end
  end

  // A pop that completes the word in the flush cycle makes it a plain full word.
  always_comb begin
    fp_d = (fp_q && !xfer) || (flush_req && cnt_d != 3'd0 && cnt_d != 3'd4);
    if (state_q == ST_FILL && bus.rempty && !fp_d) begin
      idle_d = idle_q + 8'd1;
    end else begin
      idle_d = 8'd0;
    end
  end

  always_comb begin
    if (cnt_d == 3'd0) begin
      state_d = ST_EMPTY;
    end else if (cnt_d == 3'd4) begin
      state_d = ST_FULL;
    end else if (fp_d) begin
      state_d = ST_FLUSH;
    end else begin
      state_d = ST_FILL;
    end
  end

  // Unused lanes of acc_q are already zero because it clears on every xfer.
  always_comb begin
    m_valid_d = m_valid_q && !bus.m_ready;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    if (xfer) begin
      m_valid_d = 1'b1;
      m_data_d  = acc_q;
      case (cnt_q)
        3'd1:    m_keep_d = 4'b0001;
        3'd2:    m_keep_d = 4'b0011;
        3'd3:    m_keep_d = 4'b0111;
        default: m_keep_d = 4'b1111;
      endcase
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_q   <= ST_EMPTY;
      cnt_q     <= 3'd0;
      acc_q     <= 32'h0;
      idle_q    <= 8'd0;
      fp_q      <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= 32'h0;
      m_keep_q  <= 4'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      idle_q    <= idle_d;
      fp_q      <= fp_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
    end
  end

  assign bus.rinc    = pop;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_keep  = m_keep_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fifo_read_packer.sv
// Directed bench for fifo_read_packer: a queue-based packing model checked every
// cycle, plus literal expected words in a scoreboard queue.
module tb_fifo_read_packer;
  localparam int TIMEOUT = 15;

  logic       rclk = 1'b0;
  logic       rrst = 1'b1;
  logic [1:0] dbg_state;

  fifo_read_packer_if bus ();

  fifo_read_packer #(.TIMEOUT(TIMEOUT)) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 rclk = ~rclk;

  // ---------------- bookkeeping ----------------
  int          checks = 0;
  int          errors = 0;
  int          mv_seen = 0;
  int          dut_pops = 0;
  logic [35:0] exp_q[$];
  logic [7:0]  fifo_q[$];

  // Model state: bytes gathered so far, pending-flush flag, idle count, slot.
  logic [7:0]  m_acc[$];
  bit          m_pend;
  int          m_idle;
  bit          m_sv;
  logic [31:0] m_sd;
  logic [3:0]  m_sk;
  bit          pop_exp;

  task automatic check(input string name, input logic [35:0] got, input logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic update_pins();
    bus.rempty = (fifo_q.size() == 0);
    bus.rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic model_reset();
    m_acc.delete();
    m_pend  = 1'b0;
    m_idle  = 0;
    m_sv    = 1'b0;
    m_sd    = 32'h0;
    m_sk    = 4'h0;
    pop_exp = 1'b0;
  endtask

  // One cycle of the packing rules, evaluated on the inputs seen this cycle.
  task automatic model_step();
    int          n;
    bit          was_fill;
    bit          pend_pre;
    bit          emit;
    bit          req;
    logic [31:0] word;
    n        = m_acc.size();
    was_fill = (n >= 1 && n <= 3 && !m_pend);
    pend_pre = m_pend;
    emit     = (!m_sv || bus.m_ready) && (n == 4 || m_pend);
    pop_exp  = !bus.rempty && !m_pend && (n < 4 || emit);
    check("rinc", 36'(bus.rinc), 36'(pop_exp));
    if (emit) begin
      word = 32'h0;
      for (int i = 0; i < n; i++) word = word | (32'(m_acc[i]) << (8 * i));
      m_sd   = word;
      m_sk   = 4'((1 << n) - 1);
      m_sv   = 1'b1;
      m_pend = 1'b0;
      m_acc.delete();
    end else if (m_sv && bus.m_ready) begin
      m_sv = 1'b0;
    end
    if (pop_exp) m_acc.push_back(bus.rdata);
    if (was_fill && bus.rempty) m_idle++;
    else m_idle = 0;
    req = (bus.flush && !pend_pre) || (m_idle == TIMEOUT);
    if (req && m_acc.size() >= 1 && m_acc.size() <= 3) begin
      m_pend = 1'b1;
      m_idle = 0;
    end
  endtask

  // ---------------- compare process ----------------
  initial begin
    model_reset();
    forever begin
      @(negedge rclk);
      if (rrst) begin
        check("rinc_in_reset", 36'(bus.rinc), 36'h0);
        model_reset();
      end else begin
        if (bus.m_valid && bus.m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %h expected none", {bus.m_keep, bus.m_data});
          end else begin
            check("word", {bus.m_keep, bus.m_data}, exp_q.pop_front());
          end
        end
        if (bus.rinc) dut_pops++;
        if (bus.m_valid) mv_seen++;
        model_step();
      end
      @(posedge rclk);
      #1;
      if (pop_exp && fifo_q.size() != 0) begin
        void'(fifo_q.pop_front());
        update_pins();
      end
      check("m_valid", 36'(bus.m_valid), 36'(m_sv));
      if (m_sv) begin
        check("m_data", 36'(bus.m_data), 36'(m_sd));
        check("m_keep", 36'(bus.m_keep), 36'(m_sk));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge rclk);
    #2;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    update_pins();
  endtask

  task automatic do_reset(input logic ready);
    tick(1);
    rrst = 1'b1;
    bus.flush = 1'b0;
    bus.m_ready = ready;
    fifo_q.delete();
    update_pins();
    tick(2);
    check("rst_m_valid", 36'(bus.m_valid), 36'h0);
    check("rst_m_keep", 36'(bus.m_keep), 36'h0);
    check("rst_rinc", 36'(bus.rinc), 36'h0);
    check("rst_state", 36'(dbg_state), 36'h0);
    rrst = 1'b0;
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    tick(1);
    bus.flush = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    bus.flush   = 1'b0;
    bus.m_ready = 1'b0;
    update_pins();

    // Streaming at full rate: eight bytes, two full words.
    do_reset(1'b1);
    exp_q.push_back({4'hF, 32'h44332211});
    exp_q.push_back({4'hF, 32'h88776655});
    for (int i = 1; i <= 8; i++) push(8'(i * 8'h11));
    dut_pops = 0;
    tick(8);
    check("t1_pops", 36'(dut_pops), 36'd8);
    tick(6);
    check("t1_words_left", 36'(exp_q.size()), 36'd0);

    // Backpressure: slot held, accumulator full, pops stalled.
    do_reset(1'b0);
    exp_q.push_back({4'hF, 32'h04030201});
    exp_q.push_back({4'hF, 32'h08070605});
    exp_q.push_back({4'hF, 32'h0C0B0A09});
    for (int i = 1; i <= 12; i++) push(8'(i));
    tick(12);
    check("t2_rinc_stalled", 36'(bus.rinc), 36'h0);
    check("t2_held_data", 36'(bus.m_data), 36'h004030201);
    check("t2_state_full", 36'(dbg_state), 36'd2);
    bus.m_ready = 1'b1;
    #1;
    check("t2_rinc_resume", 36'(bus.rinc), 36'h1);
    tick(10);
    check("t2_words_left", 36'(exp_q.size()), 36'd0);

    // Idle timeout emits a 3-byte partial word.
    do_reset(1'b1);
    exp_q.push_back({4'h7, 32'h00CCBBAA});
    push(8'hAA);
    push(8'hBB);
    push(8'hCC);
    tick(25);
    check("t3_words_left", 36'(exp_q.size()), 36'd0);

    // Explicit flush with two bytes, then flush with nothing held.
    do_reset(1'b1);
    exp_q.push_back({4'h3, 32'h00002211});
    push(8'h11);
    push(8'h22);
    tick(4);
    pulse_flush();
    tick(4);
    check("t4_words_left", 36'(exp_q.size()), 36'd0);
    mv_seen = 0;
    pulse_flush();
    tick(5);
    check("t4_empty_flush", 36'(mv_seen), 36'd0);
    check("t4_state_empty", 36'(dbg_state), 36'd0);

    // Flush coinciding with a pop; later byte blocked until the word leaves.
    do_reset(1'b1);
    exp_q.push_back({4'h7, 32'h00332211});
    exp_q.push_back({4'h1, 32'h00000044});
    push(8'h11);
    push(8'h22);
    tick(2);
    push(8'h33);
    pulse_flush();
    push(8'h44);
    #1;
    check("t5_rinc_blocked", 36'(bus.rinc), 36'h0);
    tick(22);
    check("t5_words_left", 36'(exp_q.size()), 36'd0);

    // Reset mid-operation drops the held word and the partial bytes.
    do_reset(1'b0);
    for (int i = 1; i <= 8; i++) push(8'(i));
    tick(7);
    check("t6_pre_valid", 36'(bus.m_valid), 36'h1);
    check("t6_pre_rinc", 36'(bus.rinc), 36'h1);
    rrst = 1'b1;
    #1;
    check("t6_rst_valid", 36'(bus.m_valid), 36'h0);
    check("t6_rst_keep", 36'(bus.m_keep), 36'h0);
    check("t6_rst_rinc", 36'(bus.rinc), 36'h0);
    fifo_q.delete();
    update_pins();
    bus.m_ready = 1'b1;
    tick(2);
    rrst = 1'b0;
    mv_seen = 0;
    tick(25);
    check("t6_no_emit", 36'(mv_seen), 36'd0);
    exp_q.push_back({4'hF, 32'hA4A3A2A1});
    exp_q.push_back({4'h1, 32'h000000A5});
    for (int i = 1; i <= 5; i++) push(8'(8'hA0 + i));
    tick(25);
    check("t6_words_left", 36'(exp_q.size()), 36'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
